// File: rtl/cpu_control_multi.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// over a shared ALU and single memory, stalling on the memory ready handshake.
module cpu_control_multi #(
  parameter bit STALL_ON_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q, next_state;

  logic ready;
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic valid;
  logic [3:0] alu_op;
  logic wpc_raw, wir_raw, wmem_raw, wreg_raw;

  assign ready = STALL_ON_MEM ? mem_ready : 1'b1;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type & (func == 6'b100000);
  assign i_sub  = r_type & (func == 6'b100010);
  assign i_and  = r_type & (func == 6'b100100);
  assign i_or   = r_type & (func == 6'b100101);
  assign i_xor  = r_type & (func == 6'b100110);
  assign i_sll  = r_type & (func == 6'b000000);
  assign i_srl  = r_type & (func == 6'b000010);
  assign i_sra  = r_type & (func == 6'b000011);
  assign i_jr   = r_type & (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign valid = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                 i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne |
                 i_lui | i_j | i_jal;

  always_comb begin
    alu_op = 4'b0000;
    if (i_sub)                              alu_op = 4'b0100;
    else if (i_and | i_andi)                alu_op = 4'b0001;
    else if (i_or | i_ori)                  alu_op = 4'b0101;
    else if (i_xor | i_xori | i_beq | i_bne) alu_op = 4'b0010;
    else if (i_lui)                         alu_op = 4'b0110;
    else if (i_sll)                         alu_op = 4'b0011;
    else if (i_srl)                         alu_op = 4'b0111;
    else if (i_sra)                         alu_op = 4'b1111;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IF;
    else       state_q <= next_state;
  end

  // Outputs are Mealy-style: they react to op/func/z/mem_ready within the cycle.
  always_comb begin
    next_state = S_IF;
    wpc_raw    = 1'b0;
    wir_raw    = 1'b0;
    wmem_raw   = 1'b0;
    wreg_raw   = 1'b0;
    iord       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    shift      = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluc       = 4'b0000;
    pcsource   = 2'b00;
    case (state_q)
      S_IF: begin
        alusrcb    = 2'b01;
        wpc_raw    = ready;
        wir_raw    = ready;
        next_state = ready ? S_ID : S_IF;
      end
      S_ID: begin
        alusrcb = 2'b11;
        if (i_j) begin
          wpc_raw  = 1'b1;
          pcsource = 2'b11;
        end else if (i_jal) begin
          wpc_raw  = 1'b1;
          pcsource = 2'b11;
          wreg_raw = 1'b1;
          jal      = 1'b1;
        end else if (i_jr) begin
          wpc_raw  = 1'b1;
          pcsource = 2'b10;
        end else if (valid) begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        shift   = i_sll | i_srl | i_sra;
        alusrcb = (r_type | i_beq | i_bne) ? 2'b00 : 2'b10;
        aluc    = alu_op;
        if (i_beq | i_bne) begin
          wpc_raw  = (i_beq & z) | (i_bne & ~z);
          pcsource = 2'b01;
        end else if (i_lw | i_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        iord     = 1'b1;
        wmem_raw = i_sw;
        if (!ready)     next_state = S_MEM;
        else if (i_lw)  next_state = S_WB;
      end
      S_WB: begin
        wreg_raw = 1'b1;
        m2reg    = i_lw;
        regrt    = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
      end
      default: next_state = S_IF;
    endcase
  end

  // Write enables drop the instant reset asserts, even mid-access.
  assign wpc   = wpc_raw & clrn;
  assign wir   = wir_raw & clrn;
  assign wmem  = wmem_raw & clrn;
  assign wreg  = wreg_raw & clrn;
  assign sext  = i_addi | i_lw | i_sw | i_beq | i_bne;
  assign state = state_q;

endmodule

// File: tb/tb_cpu_control_multi.sv
// Directed self-checking bench for cpu_control_multi: walks each instruction
// class through its state sequence and checks control outputs per cycle.
module tb_cpu_control_multi;

  logic       clk = 1'b0;
  logic       clrn;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  cpu_control_multi dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for IF so each scenario starts from a known fetch.
  task automatic go_idle();
    int n = 0;
    while (state !== 3'd0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL go_idle: state=%0d required 0", state);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; mem_ready = 1'b1; z = 1'b0; op = 6'h3f; func = 6'h3f;
    #3;
    checks++;
    if ({state, wpc, wir, wmem, wreg} !== 7'b000_0000) begin
      errors++;
      $display("[TB] FAIL reset: state=%0d wpc/wir/wmem/wreg=%b required 0/0000",
               state, {wpc, wir, wmem, wreg});
    end
    tick();
    clrn = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({state, wpc, wir} !== 5'b000_00) begin
        errors++;
        $display("[TB] FAIL if_wait[%0d]: state=%0d wpc=%b wir=%b required 0/0/0", i, state, wpc, wir);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({wpc, wir, alusrcb} !== 4'b11_01) begin
      errors++;
      $display("[TB] FAIL if_ready: wpc=%b wir=%b alusrcb=%b required 1/1/01", wpc, wir, alusrcb);
    end
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL if_to_id: state=%0d required 1", state);
    end
  endtask

  task automatic test_undefined();
    // Entered with op=111111 already sitting in ID from the reset scenario.
    #1;
    checks++;
    if ({wpc, wir, wmem, wreg} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL undef_id: writes=%b required 0000", {wpc, wir, wmem, wreg});
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL undef_next: state=%0d required 0", state);
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [3:0] exp_aluc, input logic exp_shift);
    go_idle();
    op = 6'b000000; func = f; mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL r_id f=%b: state=%0d required 1", f, state);
    end
    tick();
    checks++;
    if ({state, aluc, alusrcb, alusrca, shift} !== {3'd2, exp_aluc, 2'b00, 1'b1, exp_shift}) begin
      errors++;
      $display("[TB] FAIL r_exe f=%b: state=%0d aluc=%b alusrcb=%b alusrca=%b shift=%b required 2/%b/00/1/%b",
               f, state, aluc, alusrcb, alusrca, shift, exp_aluc, exp_shift);
    end
    tick();
    checks++;
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b100}) begin
      errors++;
      $display("[TB] FAIL r_wb f=%b: state=%0d wreg=%b regrt=%b m2reg=%b required 4/1/0/0",
               f, state, wreg, regrt, m2reg);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL r_done f=%b: state=%0d required 0 after 4 cycles", f, state);
    end
  endtask

  task automatic test_lw_stall();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    go_idle();
    op = 6'b100011; func = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (state !== exp_seq[i]) begin
        errors++;
        $display("[TB] FAIL lw_seq[%0d]: state=%0d required %0d", i, state, exp_seq[i]);
      end
      if (exp_seq[i] == 3'd3) begin
        checks++;
        if ({iord, wmem} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL lw_mem[%0d]: iord=%b wmem=%b required 1/0", i, iord, wmem);
        end
      end
      if (i == 6) begin
        checks++;
        if ({m2reg, regrt, sext, wreg} !== 4'b1111) begin
          errors++;
          $display("[TB] FAIL lw_wb: m2reg=%b regrt=%b sext=%b wreg=%b required 1111",
                   m2reg, regrt, sext, wreg);
        end
      end
      if (i == 2) begin
        checks++;
        if ({alusrcb, aluc} !== 6'b10_0000) begin
          errors++;
          $display("[TB] FAIL lw_exe: alusrcb=%b aluc=%b required 10/0000", alusrcb, aluc);
        end
      end
      tick();
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL lw_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_branch(input logic [5:0] o, input logic zf, input logic exp_wpc);
    go_idle();
    op = o; func = 6'b000000; mem_ready = 1'b1; z = zf;
    tick();
    checks++;
    if ({state, alusrcb} !== {3'd1, 2'b11}) begin
      errors++;
      $display("[TB] FAIL br_id op=%b: state=%0d alusrcb=%b required 1/11", o, state, alusrcb);
    end
    tick();
    checks++;
    if ({state, wpc, pcsource, aluc, alusrcb} !== {3'd2, exp_wpc, 2'b01, 4'b0010, 2'b00}) begin
      errors++;
      $display("[TB] FAIL br_exe op=%b z=%b: state=%0d wpc=%b pcsource=%b aluc=%b alusrcb=%b required 2/%b/01/0010/00",
               o, zf, state, wpc, pcsource, aluc, alusrcb, exp_wpc);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL br_done op=%b: state=%0d required 0", o, state);
    end
    z = 1'b0;
  endtask

  task automatic test_jump(input logic [5:0] o, input logic [5:0] f, input logic [1:0] exp_pcs,
                           input logic exp_link);
    go_idle();
    op = o; func = f; mem_ready = 1'b1;
    tick();
    checks++;
    if ({state, wpc, pcsource, wreg, jal} !== {3'd1, 1'b1, exp_pcs, exp_link, exp_link}) begin
      errors++;
      $display("[TB] FAIL jump_id op=%b f=%b: state=%0d wpc=%b pcsource=%b wreg=%b jal=%b required 1/1/%b/%b/%b",
               o, f, state, wpc, pcsource, wreg, jal, exp_pcs, exp_link, exp_link);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL jump_done op=%b: state=%0d required 0", o, state);
    end
  endtask

  task automatic test_sw_reset();
    go_idle();
    op = 6'b101011; func = 6'b000000; mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if ({state, wmem, iord} !== {3'd3, 2'b11}) begin
      errors++;
      $display("[TB] FAIL sw_mem: state=%0d wmem=%b iord=%b required 3/1/1", state, wmem, iord);
    end
    tick();
    checks++;
    if ({state, wmem} !== {3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sw_hold: state=%0d wmem=%b required 3/1", state, wmem);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if ({state, wmem, wpc, wreg} !== {3'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL sw_abort: state=%0d wmem=%b wpc=%b wreg=%b required 0/0/0/0",
               state, wmem, wpc, wreg);
    end
    tick();
    clrn = 1'b1; mem_ready = 1'b1; op = 6'b111111;
    #1;
    checks++;
    if ({state, wpc, wir} !== {3'd0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL sw_restart: state=%0d wpc=%b wir=%b required 0/1/1", state, wpc, wir);
    end
    tick();
    test_undefined();
  endtask

  initial begin
    test_reset();
    test_undefined();
    test_rtype(6'b100000, 4'b0000, 1'b0);
    test_rtype(6'b000011, 4'b1111, 1'b1);
    test_rtype(6'b100010, 4'b0100, 1'b0);
    test_lw_stall();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_jump(6'b000011, 6'b000000, 2'b11, 1'b1);
    test_jump(6'b000010, 6'b000000, 2'b11, 1'b0);
    test_jump(6'b000000, 6'b001000, 2'b10, 1'b0);
    test_sw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
